fetch_pc_unit: RTL and testbench

- Fetch-stage PC generator; sits directly upstream of the branch predictor.
- Drives the current PC to the predictor and instruction memory.
- Consumes the prediction (btb_hit, bp_pc) to choose the next PC and accepts mispredict redirects from EX.
- Holds fetch metadata in a one-entry skid register when decode stalls; emits registered fetch records to the IF/ID latch.

---
 rtl/fetch_pc_unit_if.sv | 36 +++
 rtl/fetch_pc_unit.sv | 129 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bus: predictor/imem/EX-redirect inputs and IF/ID record outputs.
// Latency: n/a (signal bundle only).
// Backpressure: stall is carried here; the unit skids one record while it is high.
// Modports:
//   master - the fetch PC unit side (consumes ihit/stall/halt/redirect/prediction, drives PC and record)
//   slave  - the surrounding pipeline / environment side
interface fetch_pc_unit_if;
    logic        ihit;
    logic        stall;
    logic        halt;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        btb_hit;
    logic [31:0] bp_pc;

    logic [31:0] curr_pc;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_npc;
    logic        fetch_pred_taken;
    logic [31:0] fetch_pred_pc;

    modport master (
        input  ihit, stall, halt, redirect_en, redirect_pc, btb_hit, bp_pc,
        output curr_pc, imemREN, imemaddr, fetch_valid, fetch_pc, fetch_npc,
               fetch_pred_taken, fetch_pred_pc
    );

    modport slave (
        output ihit, stall, halt, redirect_en, redirect_pc, btb_hit, bp_pc,
        input  curr_pc, imemREN, imemaddr, fetch_valid, fetch_pc, fetch_npc,
               fetch_pred_taken, fetch_pred_pc
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: picks next PC from predictor/redirect, emits registered fetch records.
// Latency: record appears 1 cycle after an accepted ihit (fetch_valid one-cycle pulse).
// Backpressure: stall on ihit parks the record in a one-entry skid (HOLD, imem read off) until released.
// Ports: CLK, nRST (async active-low), bus (fetch_pc_unit_if.master).
// Optional: define FETCH_PERF_CNT_EN to add fetch_cnt / redirect_cnt counter outputs.
module fetch_pc_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            nRST,
    fetch_pc_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     redirect_cnt
`endif
);

    localparam logic [1:0] FETCH  = 2'b00;
    localparam logic [1:0] HOLD   = 2'b01;
    localparam logic [1:0] HALTED = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        taken;
        logic [31:0] pred;
    } rec_t;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    rec_t        skid_q, skid_d;
    rec_t        out_q, out_d;
    logic        fetch_valid_q;

    logic [31:0] pc_plus4;
    logic [31:0] npc;
    rec_t        cur_rec;
    logic        accept;
    logic        redirect_take;

    // Low address bits of targets are discarded by word alignment.
    logic        unused_bits;
    assign unused_bits = ^{bus.bp_pc[1:0], bus.redirect_pc[1:0]};

    assign pc_plus4 = pc_q + 32'd4;
    assign npc      = bus.btb_hit ? {bus.bp_pc[31:2], 2'b00} : pc_plus4;
    assign cur_rec  = '{pc: pc_q, npc: pc_plus4, taken: bus.btb_hit, pred: npc};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        skid_d        = skid_q;
        out_d         = out_q;
        accept        = 1'b0;
        redirect_take = 1'b0;
        if (state_q != HALTED) begin
            if (bus.halt) begin
                // Halt wins over everything; any parked record is simply abandoned.
                state_d = HALTED;
            end else if (bus.redirect_en) begin
                // Redirect discards both the skid entry and any same-cycle ihit.
                pc_d          = {bus.redirect_pc[31:2], 2'b00};
                state_d       = FETCH;
                redirect_take = 1'b1;
            end else if (state_q == FETCH) begin
                if (bus.ihit) begin
                    pc_d = npc;
                    if (bus.stall) begin
                        skid_d  = cur_rec;
                        state_d = HOLD;
                    end else begin
                        accept = 1'b1;
                        out_d  = cur_rec;
                    end
                end
            end else if (!bus.stall) begin
                // HOLD: decode freed up, hand over the parked record.
                accept  = 1'b1;
                out_d   = skid_q;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= FETCH;
            pc_q          <= PC_INIT;
            skid_q        <= '0;
            out_q         <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            skid_q        <= skid_d;
            out_q         <= out_d;
            fetch_valid_q <= accept;
        end
    end

    assign bus.curr_pc          = pc_q;
    assign bus.imemaddr         = pc_q;
    assign bus.imemREN          = (state_q == FETCH);
    assign bus.fetch_valid      = fetch_valid_q;
    assign bus.fetch_pc         = out_q.pc;
    assign bus.fetch_npc        = out_q.npc;
    assign bus.fetch_pred_taken = out_q.taken;
    assign bus.fetch_pred_pc    = out_q.pred;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, redirect_cnt_q;

    // fetch_cnt steps on the same edge that raises fetch_valid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (accept)        fetch_cnt_q    <= fetch_cnt_q + 32'd1;
            if (redirect_take) redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt    = fetch_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a record scoreboard checked by an independent monitor.
module tb_fetch_pc_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        taken;
        logic [31:0] pred;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    fetch_pc_unit_if bus();

    fetch_pc_unit #(.PC_INIT(32'h0)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] npc,
                        input logic taken, input logic [31:0] pred);
        exp_t e;
        e.pc = pc; e.npc = npc; e.taken = taken; e.pred = pred;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic ihit, input logic stall, input logic halt,
                         input logic ren, input logic [31:0] rpc,
                         input logic hit, input logic [31:0] bpc);
        bus.ihit = ihit; bus.stall = stall; bus.halt = halt;
        bus.redirect_en = ren; bus.redirect_pc = rpc;
        bus.btb_hit = hit; bus.bp_pc = bpc;
    endtask

    // Monitor: every record the DUT presents must match the oldest expectation.
    always @(negedge CLK) begin
        if (nRST && bus.fetch_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_record: got fetch_pc %h, required no fetch_valid", bus.fetch_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rec_pc",    bus.fetch_pc,                 e.pc);
                check("rec_npc",   bus.fetch_npc,                e.npc);
                check("rec_taken", {31'b0, bus.fetch_pred_taken}, {31'b0, e.taken});
                check("rec_pred",  bus.fetch_pred_pc,            e.pred);
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        nRST = 1'b0;
        repeat (3) tick();
        check("rst_pc",    bus.curr_pc, 32'h0);
        check("rst_valid", {31'b0, bus.fetch_valid}, 32'h0);
        check("rst_fpc",   bus.fetch_pc, 32'h0);
        check("rst_fnpc",  bus.fetch_npc, 32'h0);
        check("rst_fpred", bus.fetch_pred_pc, 32'h0);

        // Straight-line fetch, one record per cycle.
        nRST = 1'b1;
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        push(32'h0, 32'h4, 0, 32'h4);
        tick(); check("seq_pc4", bus.curr_pc, 32'h4);
        check("ren_after_rst", {31'b0, bus.imemREN}, 32'h1);
        push(32'h4, 32'h8, 0, 32'h8);
        tick(); check("seq_pc8", bus.curr_pc, 32'h8);
        check("imemaddr", bus.imemaddr, 32'h8);
        push(32'h8, 32'hC, 0, 32'hC);
        tick(); push(32'hC, 32'h10, 0, 32'h10);
        tick(); check("seq_pc10", bus.curr_pc, 32'h10);

        // Predicted-taken branch with misaligned target bits.
        drive(1, 0, 0, 0, 32'h0, 1, 32'h42);
        push(32'h10, 32'h14, 1, 32'h40);
        tick(); check("btb_pc", bus.curr_pc, 32'h40);
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        push(32'h40, 32'h44, 0, 32'h44);
        tick();

        // Redirect to 0x20 with a discarded same-cycle ihit.
        drive(1, 0, 0, 1, 32'h20, 0, 32'h0);
        tick(); check("redir_pc20", bus.curr_pc, 32'h20);
        check("redir_novalid", {31'b0, bus.fetch_valid}, 32'h0);

        // Stall three cycles on an ihit at 0x20.
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_ren", {31'b0, bus.imemREN}, 32'h0);
            check("hold_valid", {31'b0, bus.fetch_valid}, 32'h0);
        end
        check("hold_pc", bus.curr_pc, 32'h24);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        push(32'h20, 32'h24, 0, 32'h24);
        tick(); check("release_ren", {31'b0, bus.imemREN}, 32'h1);
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        push(32'h24, 32'h28, 0, 32'h28);
        tick(); check("resume_pc", bus.curr_pc, 32'h28);

        // Redirect while HOLD drops the skid entry.
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        tick(); check("hold2_pc", bus.curr_pc, 32'h2C);
        drive(0, 0, 0, 1, 32'h103, 0, 32'h0);
        tick(); check("skid_drop_pc", bus.curr_pc, 32'h100);
        check("skid_drop_valid", {31'b0, bus.fetch_valid}, 32'h0);
        check("skid_drop_ren", {31'b0, bus.imemREN}, 32'h1);
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        push(32'h100, 32'h104, 0, 32'h104);
        tick();

        // Halt beats redirect at 0x30.
        drive(0, 0, 0, 1, 32'h30, 0, 32'h0);
        tick(); check("to30_pc", bus.curr_pc, 32'h30);
        drive(1, 0, 1, 1, 32'h200, 0, 32'h0);
        tick(); check("halt_pc", bus.curr_pc, 32'h30);
        check("halt_ren", {31'b0, bus.imemREN}, 32'h0);
        drive(1, 0, 0, 1, 32'h300, 1, 32'h80);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halted_pc", bus.curr_pc, 32'h30);
            check("halted_valid", {31'b0, bus.fetch_valid}, 32'h0);
        end

        // Leave HALTED via reset, then reset again while a record is parked.
        nRST = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        tick(); nRST = 1'b1;
        check("rerst_pc", bus.curr_pc, 32'h0);
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        tick(); check("park_pc", bus.curr_pc, 32'h4);
        #2 nRST = 1'b0;
        #1 check("async_pc", bus.curr_pc, 32'h0);
        check("async_fpc", bus.fetch_pc, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        tick(); nRST = 1'b1;
        tick(); check("post_rst_pc", bus.curr_pc, 32'h0);
        check("post_rst_ren", {31'b0, bus.imemREN}, 32'h1);
        check("post_rst_valid", {31'b0, bus.fetch_valid}, 32'h0);

        // PC+4 wraps at the top of the address space.
        drive(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0);
        tick(); check("top_pc", bus.curr_pc, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        push(32'hFFFF_FFFC, 32'h0, 0, 32'h0);
        tick(); check("wrap_pc", bus.curr_pc, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        tick(); check("nohit_hold_pc", bus.curr_pc, 32'h0);
        tick();
        check("queue_drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
